// File: rtl/glitch_pkg.sv
// Shared types for the clock glitch sequencer: FSM states and the per-slot configuration record.
package glitch_pkg;

  localparam int unsigned SLOT_CYC_W  = 16;
  localparam int unsigned SLOT_TICK_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    COUNT,
    OFFSET,
    PULSE,
    DONE
  } gs_state_e;

  typedef struct packed {
    logic                   en;
    logic [SLOT_CYC_W-1:0]  cyc;
    logic [SLOT_TICK_W-1:0] off;
    logic [SLOT_TICK_W-1:0] wid;
  } slot_cfg_t;

endpackage

// File: rtl/clock_glitch_sequencer_if.sv
// Control link between the sequencer FSM (master) and its pulse timer (slave).
interface clock_glitch_sequencer_if #(
  parameter int unsigned TICK_W = 6
);
  logic              start;
  logic              abort;
  logic [TICK_W-1:0] off;
  logic [TICK_W-1:0] wid;
  logic              pulse;
  logic              pulse_next;
  logic              finished;

  modport master (output start, abort, off, wid, input pulse, pulse_next, finished);
  modport slave  (input start, abort, off, wid, output pulse, pulse_next, finished);
endinterface

// File: rtl/glitch_pulse_timer.sv
// Offset/width down-counter: after start, waits off ticks then holds the registered pulse for wid ticks.
module glitch_pulse_timer #(
  parameter int unsigned TICK_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  clock_glitch_sequencer_if.slave  tmr
);

  logic [TICK_W-1:0] off_q, off_d;
  logic [TICK_W-1:0] wid_q, wid_d;
  logic              pulse_q, pulse_d;

  // Offset drains first; width only counts once the offset is exhausted.
  always_comb begin
    off_d = off_q;
    wid_d = wid_q;
    if (tmr.abort) begin
      off_d = '0;
      wid_d = '0;
    end else if (tmr.start) begin
      off_d = tmr.off;
      wid_d = tmr.wid;
    end else if (off_q != '0) begin
      off_d = off_q - TICK_W'(1);
    end else if (wid_q != '0) begin
      wid_d = wid_q - TICK_W'(1);
    end
    pulse_d = (off_d == '0) && (wid_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q   <= '0;
      wid_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      off_q   <= off_d;
      wid_q   <= wid_d;
      pulse_q <= pulse_d;
    end
  end

  assign tmr.pulse      = pulse_q;
  assign tmr.pulse_next = pulse_d;
  assign tmr.finished   = (off_q == '0) && (wid_q == TICK_W'(1));

endmodule

// File: rtl/clock_glitch_sequencer.sv
// Counts target-clock rising edges after a GPIO trigger and emits one timed glitch pulse per eligible slot.
module clock_glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int unsigned GP        = 8,
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned CYC_W     = SLOT_CYC_W,
  parameter int unsigned TICK_W    = SLOT_TICK_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tgt_clk,
  input  logic [GP-1:0]                 gpio_in,
  input  logic [$clog2(GP)-1:0]         trig_sel,
  input  logic                          arm,
  input  logic [NUM_SLOTS-1:0]          slot_en,
  input  logic [NUM_SLOTS*CYC_W-1:0]    slot_cyc,
  input  logic [NUM_SLOTS*TICK_W-1:0]   slot_off,
  input  logic [NUM_SLOTS*TICK_W-1:0]   slot_wid,
  output logic                          glitch,
  output logic                          busy,
  output logic                          done,
  output logic                          aborted,
  output logic [$clog2(NUM_SLOTS+1)-1:0] fired_cnt
);

  localparam int unsigned SEL_W = $clog2(GP);
  localparam int unsigned IDX_W = $clog2(NUM_SLOTS + 1);

  gs_state_e         state_q, state_d;
  slot_cfg_t         cfg_q [NUM_SLOTS];
  slot_cfg_t         cfg_d [NUM_SLOTS];
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              trig_prev_q, trig_prev_d;
  logic              tgt_prev_q, tgt_prev_d;
  logic [CYC_W-1:0]  cnt_q, cnt_d;
  logic [CYC_W-1:0]  last_cyc_q, last_cyc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  fired_cnt_q, fired_cnt_d;
  logic              busy_q, busy_d, done_q, done_d, aborted_q, aborted_d;

  logic              trig_c, rise_c, fall_c, edge_c, start_c, abort_c, found_c;
  logic [IDX_W-1:0]  pick_c;
  logic [CYC_W-1:0]  pick_cyc_c;
  logic [TICK_W-1:0] pick_off_c, pick_wid_c;

  clock_glitch_sequencer_if #(.TICK_W(TICK_W)) tmr_if ();

  glitch_pulse_timer #(.TICK_W(TICK_W)) u_timer (
    .clk (clk),
    .rst (rst),
    .tmr (tmr_if.slave)
  );

  assign trig_c = gpio_in[sel_q];
  assign rise_c = trig_c & ~trig_prev_q;
  assign fall_c = ~trig_c & trig_prev_q;
  assign edge_c = tgt_clk & ~tgt_prev_q;

  // Lowest slot at or after idx_q that is enabled, non-zero width and strictly later than the last fired cycle.
  always_comb begin
    found_c    = 1'b0;
    pick_c     = '0;
    pick_cyc_c = '0;
    pick_off_c = '0;
    pick_wid_c = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if ((IDX_W'(k) >= idx_q) && cfg_q[k].en && (cfg_q[k].wid != '0) &&
          ((fired_cnt_q == '0) || (CYC_W'(cfg_q[k].cyc) > last_cyc_q))) begin
        found_c    = 1'b1;
        pick_c     = IDX_W'(k);
        pick_cyc_c = CYC_W'(cfg_q[k].cyc);
        pick_off_c = TICK_W'(cfg_q[k].off);
        pick_wid_c = TICK_W'(cfg_q[k].wid);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    last_cyc_d  = last_cyc_q;
    idx_d       = idx_q;
    fired_cnt_d = fired_cnt_q;
    start_c     = 1'b0;
    abort_c     = 1'b0;

    // Target edges keep counting while a pulse is in flight; the counter sticks at all-ones.
    if ((state_q == COUNT || state_q == OFFSET || state_q == PULSE) && edge_c && (cnt_q != '1))
      cnt_d = cnt_q + CYC_W'(1);

    case (state_q)
      IDLE: if (arm) begin
        state_d     = ARMED;
        sel_d       = trig_sel;
        cnt_d       = '0;
        last_cyc_d  = '0;
        idx_d       = '0;
        fired_cnt_d = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
          cfg_d[k].en  = slot_en[k];
          cfg_d[k].cyc = SLOT_CYC_W'(slot_cyc[k*CYC_W +: CYC_W]);
          cfg_d[k].off = SLOT_TICK_W'(slot_off[k*TICK_W +: TICK_W]);
          cfg_d[k].wid = SLOT_TICK_W'(slot_wid[k*TICK_W +: TICK_W]);
        end
      end
      ARMED: if (rise_c) begin
        state_d = COUNT;
        cnt_d   = '0;
      end
      COUNT: begin
        if (fall_c) begin
          abort_c = 1'b1;
        end else if (!found_c) begin
          state_d = DONE;
        end else if (edge_c && (cnt_q == pick_cyc_c)) begin
          start_c    = 1'b1;
          last_cyc_d = pick_cyc_c;
          idx_d      = pick_c + IDX_W'(1);
          state_d    = (pick_off_c == '0) ? PULSE : OFFSET;
        end
      end
      OFFSET: begin
        if (fall_c)                 abort_c = 1'b1;
        else if (tmr_if.pulse_next) state_d = PULSE;
      end
      PULSE: begin
        if (fall_c) begin
          abort_c = 1'b1;
        end else if (tmr_if.finished) begin
          fired_cnt_d = fired_cnt_q + IDX_W'(1);
          state_d     = COUNT;
        end
      end
      DONE:    if (arm) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort_c) state_d = DONE;

    busy_d      = state_d inside {ARMED, COUNT, OFFSET, PULSE};
    done_d      = (state_d == DONE);
    aborted_d   = done_d && (aborted_q || abort_c);
    tgt_prev_d  = tgt_clk;
    trig_prev_d = gpio_in[sel_d];
  end

  assign tmr_if.start = start_c;
  assign tmr_if.abort = abort_c;
  assign tmr_if.off   = pick_off_c;
  assign tmr_if.wid   = pick_wid_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      for (int k = 0; k < NUM_SLOTS; k++) cfg_q[k] <= '0;
      sel_q       <= '0;
      trig_prev_q <= 1'b0;
      tgt_prev_q  <= 1'b0;
      cnt_q       <= '0;
      last_cyc_q  <= '0;
      idx_q       <= '0;
      fired_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      sel_q       <= sel_d;
      trig_prev_q <= trig_prev_d;
      tgt_prev_q  <= tgt_prev_d;
      cnt_q       <= cnt_d;
      last_cyc_q  <= last_cyc_d;
      idx_q       <= idx_d;
      fired_cnt_q <= fired_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  assign glitch    = tmr_if.pulse;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign fired_cnt = fired_cnt_q;

endmodule

// File: tb/tb_clock_glitch_sequencer.sv
// Scoreboard bench for clock_glitch_sequencer: directed slot programs, pulse timing checked against recorded target edges.
module tb_clock_glitch_sequencer;

  localparam int unsigned GP = 8;
  localparam int unsigned NS = 4;
  localparam int unsigned CW = 16;
  localparam int unsigned TW = 6;

  typedef struct { int edge_idx; int off; int wid; } exp_pulse_t;
  typedef struct { int fired; int ab; } exp_res_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tgt_clk = 1'b0;
  logic              arm = 1'b0;
  logic [GP-1:0]     gpio_in = '0;
  logic [2:0]        trig_sel = '0;
  logic [NS-1:0]     slot_en = '0;
  logic [NS*CW-1:0]  slot_cyc = '0;
  logic [NS*TW-1:0]  slot_off = '0;
  logic [NS*TW-1:0]  slot_wid = '0;
  logic              glitch, busy, done, aborted;
  logic [2:0]        fired_cnt;

  int         checks = 0;
  int         failures = 0;
  longint     tick = 0;
  longint     trig_time = 0;
  bit         trig_on = 1'b0;
  int         ph = 9;
  longint     edge_q[$];
  exp_pulse_t exp_q[$];
  exp_res_t   res_q[$];

  clock_glitch_sequencer dut (
    .clk(clk), .rst(rst), .tgt_clk(tgt_clk), .gpio_in(gpio_in), .trig_sel(trig_sel),
    .arm(arm), .slot_en(slot_en), .slot_cyc(slot_cyc), .slot_off(slot_off), .slot_wid(slot_wid),
    .glitch(glitch), .busy(busy), .done(done), .aborted(aborted), .fired_cnt(fired_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (tick %0d)", name, act, exp, tick);
    end
  endtask

  // Target clock: period 10 clk, high for 5; rising edges after the trigger are timestamped.
  initial begin
    forever begin
      @(negedge clk);
      ph = (ph == 9) ? 0 : ph + 1;
      tgt_clk = (ph < 5);
      if (ph == 0 && trig_on && tick > trig_time) edge_q.push_back(tick);
    end
  end

  task automatic pulse_end(input longint st, input longint w);
    exp_pulse_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_pulse_start", st, -1);
      return;
    end
    e = exp_q.pop_front();
    if (e.edge_idx >= edge_q.size()) begin
      chk("edge_count", edge_q.size(), e.edge_idx + 1);
      return;
    end
    chk("pulse_start", st, edge_q[e.edge_idx] + 1 + e.off);
    chk("pulse_width", w, e.wid);
  endtask

  task automatic done_seen();
    exp_res_t r;
    if (res_q.size() == 0) begin
      chk("unexpected_done", 1, 0);
      return;
    end
    r = res_q.pop_front();
    chk("fired_cnt", fired_cnt, r.fired);
    chk("aborted", aborted, r.ab);
    chk("busy_in_done", busy, 0);
  endtask

  // Monitor: samples 1 time unit after each rising edge and scores pulses and completions.
  initial begin
    bit     g_prev = 1'b0;
    bit     d_prev = 1'b0;
    longint st = 0;
    forever begin
      @(posedge clk);
      #1;
      if (glitch && !g_prev) st = tick;
      if (!glitch && g_prev) pulse_end(st, tick - st);
      if (done && !d_prev) done_seen();
      g_prev = glitch;
      d_prev = done;
    end
  end

  task automatic clear_slots();
    slot_en = '0; slot_cyc = '0; slot_off = '0; slot_wid = '0;
  endtask

  task automatic set_slot(input int k, input bit en, input int cyc, input int off, input int wid);
    slot_en[k]          = en;
    slot_cyc[k*CW +: CW] = CW'(cyc);
    slot_off[k*TW +: TW] = TW'(off);
    slot_wid[k*TW +: TW] = TW'(wid);
  endtask

  task automatic push_pulse(input int e, input int off, input int wid);
    exp_pulse_t p;
    p.edge_idx = e; p.off = off; p.wid = wid;
    exp_q.push_back(p);
  endtask

  task automatic push_res(input int fired, input int ab);
    exp_res_t r;
    r.fired = fired; r.ab = ab;
    res_q.push_back(r);
  endtask

  task automatic arm_pulse();
    @(negedge clk); arm = 1'b1;
    @(negedge clk); arm = 1'b0;
  endtask

  task automatic start_seq(input int sel);
    if (done) begin
      arm_pulse();
      chk("done_clears", done, 0);
    end
    trig_sel = 3'(sel);
    arm_pulse();
    chk("busy_armed", busy, 1);
    repeat (3) @(negedge clk);
    gpio_in[sel] = 1'b1;
    trig_time    = tick;
    edge_q.delete();
    trig_on      = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic end_seq();
    @(negedge clk);
    gpio_in = '0;
    trig_on = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_glitch", glitch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_aborted", aborted, 0);
    chk("rst_fired", fired_cnt, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single slot, edge 21, offset 1, width 2.
    clear_slots(); set_slot(0, 1, 21, 1, 2);
    push_pulse(21, 1, 2); push_res(1, 0);
    start_seq(3); wait_done(1000); end_seq();

    // Three ascending slots.
    clear_slots(); set_slot(0, 1, 3, 0, 1); set_slot(1, 1, 5, 0, 1); set_slot(2, 1, 9, 0, 1);
    push_pulse(3, 0, 1); push_pulse(5, 0, 1); push_pulse(9, 0, 1); push_res(3, 0);
    start_seq(5); wait_done(1000); end_seq();

    // Non-ascending, disabled and zero-width slots are skipped.
    clear_slots(); set_slot(0, 1, 5, 0, 1); set_slot(1, 1, 4, 0, 1);
    set_slot(2, 0, 8, 0, 1); set_slot(3, 1, 9, 0, 0);
    push_pulse(5, 0, 1); push_res(1, 0);
    start_seq(0); wait_done(1000); end_seq();

    // Re-arm while busy must be ignored.
    clear_slots(); set_slot(0, 1, 2, 0, 3); set_slot(1, 1, 6, 2, 2);
    push_pulse(2, 0, 3); push_pulse(6, 2, 2); push_res(2, 0);
    start_seq(7);
    while (tick < trig_time + 45) @(negedge clk);
    clear_slots(); set_slot(0, 1, 1, 0, 4); set_slot(1, 1, 2, 0, 4); trig_sel = 3'd2;
    arm_pulse();
    chk("busy_after_rearm", busy, 1);
    wait_done(1000); end_seq();

    // Trigger falls during the pulse: pulse cut to one tick, aborted.
    clear_slots(); set_slot(0, 1, 2, 1, 5);
    push_pulse(2, 1, 1); push_res(0, 1);
    start_seq(1);
    n = 0;
    while (!glitch && n < 300) begin @(negedge clk); n++; end
    if (!glitch) chk("abort_glitch_timeout", 0, 1);
    gpio_in[1] = 1'b0;
    wait_done(100); end_seq();

    // Asynchronous reset mid-pulse.
    clear_slots(); set_slot(0, 1, 1, 0, 6);
    push_pulse(1, 0, 1);
    start_seq(4);
    n = 0;
    do begin @(posedge clk); #2; n++; end while (!glitch && n < 300);
    if (!glitch) chk("reset_glitch_timeout", 0, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_glitch", glitch, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_aborted", aborted, 0);
    chk("async_rst_fired", fired_cnt, 0);
    @(negedge clk);
    rst = 1'b0; gpio_in = '0; trig_on = 1'b0;
    repeat (3) @(negedge clk);

    // Cycle 0 boundary after reset.
    clear_slots(); set_slot(2, 1, 0, 0, 2);
    push_pulse(0, 0, 2); push_res(1, 0);
    start_seq(6); wait_done(1000); end_seq();

    repeat (5) @(negedge clk);
    chk("pulses_pending", exp_q.size(), 0);
    chk("results_pending", res_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_glitch_sequencer.md
CLOCK_GLITCH_SEQUENCER -- requirements
Module: clock_glitch_sequencer

Interface
REQ-001 SHALL have parameter GP, default 8, width of the trigger GPIO bus.
REQ-002 SHALL have parameter NUM_SLOTS, default 4, number of independent glitch slots.
REQ-003 SHALL have parameter CYC_W, default 16, width of target-cycle indices.
REQ-004 SHALL have parameter TICK_W, default 6, width of offset/width fields in fast-clock ticks.
REQ-005 SHALL have port clk  in  1  fast oversampling clock; all logic on its rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port tgt_clk  in  1  target clock level, sampled as data, synchronous to clk.
REQ-008 SHALL have port gpio_in  in  GP  DUT GPIO outputs carrying the trigger.
REQ-009 SHALL have port trig_sel  in  $clog2(GP)  trigger bit index.
REQ-010 SHALL have port arm  in  1  single-cycle pulse that latches all configuration and arms the block.
REQ-011 SHALL have port slot_en  in  NUM_SLOTS  per-slot enable.
REQ-012 SHALL have port slot_cyc  in  NUM_SLOTS*CYC_W  target-cycle index per slot.
REQ-013 SHALL have port slot_off  in  NUM_SLOTS*TICK_W  ticks from the target rising edge to the glitch start.
REQ-014 SHALL have port slot_wid  in  NUM_SLOTS*TICK_W  glitch width in ticks.
REQ-015 SHALL have port glitch  out  1  registered pulse, XORed onto the target clock outside the block.
REQ-016 SHALL have ports busy, done, aborted  out  1 each  status; plus fired_cnt  out  $clog2(NUM_SLOTS+1)  number of pulses emitted.

Function
REQ-017 SHALL implement FSM states IDLE, ARMED, COUNT, OFFSET, PULSE, DONE.
REQ-018 SHALL move IDLE->ARMED on arm, latching trig_sel and all slot_* fields into internal registers; SHALL ignore arm in every other state.
REQ-019 SHALL move ARMED->COUNT on the first clk in which gpio_in[trig_sel] is 1 and was 0 in the previous cycle, clearing the cycle counter to 0.
REQ-020 SHALL define edge E as a clk cycle with tgt_clk==1 and previous sample 0; in COUNT, each E SHALL compare against the current slot, then increment the cycle counter (first edge after trigger = cycle 0).
REQ-021 SHALL process slots in ascending index order; disabled slots, slots with wid==0, and slots whose cyc is not greater than the previous fired slot's cyc SHALL be skipped without a pulse.
REQ-022 On E with counter==slot_cyc[k], the block SHALL drive glitch high during clk cycles E+1+off .. E+off+wid inclusive (OFFSET then PULSE), then SHALL increment fired_cnt and advance to the next eligible slot in COUNT.
REQ-023 Edges arriving during OFFSET/PULSE SHALL still increment the cycle counter.
REQ-024 SHALL enter DONE when no eligible slot remains; DONE SHALL assert done and return to IDLE on the next arm.
REQ-025 If the trigger bit falls in COUNT/OFFSET/PULSE, the block SHALL drop glitch in the same next edge, set aborted and done, and enter DONE.
REQ-026 The cycle counter SHALL saturate at all-ones rather than wrap.
REQ-027 busy SHALL be 1 in ARMED, COUNT, OFFSET and PULSE, and 0 in IDLE and DONE.

Reset
REQ-028 On rst the block SHALL enter IDLE with glitch=0, busy=0, done=0, aborted=0, fired_cnt=0, and all latched configuration and counters at 0.
REQ-029 rst asserted mid-pulse SHALL force glitch low asynchronously.

Structure
REQ-030 SHALL place the FSM state enum and a packed slot_cfg_t struct {en, cyc, off, wid} in a shared package glitch_pkg.
REQ-031 SHALL use one sub-module, glitch_pulse_timer (offset/width down-counter producing the pulse), instantiated once.

Verification
REQ-032 tgt_clk period 10 clk, slot0 cyc=21 off=1 wid=2, trigger rises -> exactly one 2-tick glitch starting 2 clk after edge 21; fired_cnt=1, done=1.
REQ-033 Slots cyc=3,5,9 all wid=1 -> three pulses on edges 3, 5 and 9; fired_cnt=3.
REQ-034 Slots cyc=5 and cyc=4 -> only cyc=5 fires; fired_cnt=1.
REQ-035 Trigger falls during PULSE -> glitch 0 next clk, aborted=1, done=1.
REQ-036 rst pulsed while glitch=1 -> glitch 0 immediately; all outputs at reset values.
REQ-037 arm pulsed while busy -> ignored; configuration unchanged and sequence completes as originally armed.
